// File: rtl/des_pkg.sv
// Shared constants for the iterative DES key schedule: widths, FSM states,
// the per-round rotation amounts and the PC-2 selection table.
package des_pkg;
    localparam int KPW    = 56;
    localparam int RKW    = 48;
    localparam int NROUND = 16;
    localparam int HW     = KPW / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Left-rotate amount applied before encrypt round r (index r-1).
    localparam int unsigned SHIFT_TBL [NROUND] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Output bit n (1 = MSB) takes input bit PC2_TBL[n-1] (1 = MSB).
    localparam int unsigned PC2_TBL [RKW] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
endpackage

// File: rtl/des_pc2.sv
// PC-2 compression permutation: pure wiring from the 56-bit {C,D} to a
// 48-bit round key.
module des_pc2
    import des_pkg::*;
(
    input  logic [KPW-1:0] cd,
    output logic [RKW-1:0] rk
);
    for (genvar i = 0; i < RKW; i++) begin : g_bit
        assign rk[RKW-1-i] = cd[KPW-PC2_TBL[i]];
    end
endmodule

// File: rtl/des_key_sched.sv
// Iterative DES round-key generator: rotates C/D in place and presents one
// PC-2 subkey per handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_sched
    import des_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           e,
    input  logic [KPW-1:0] kp,
    output logic [RKW-1:0] rk,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic [3:0]     rnd,
    output logic           busy,
    output logic           done
);
    state_e         state_q, state_d;
    logic [HW-1:0]  c_q, c_d, d_q, d_d;
    logic [3:0]     rnd_q, rnd_d;
    logic           e_q, e_d;
    logic [3:0]     rnd_nx;
    logic           two;

    function automatic logic [HW-1:0] rotl(input logic [HW-1:0] x, input logic by2);
        return by2 ? {x[HW-3:0], x[HW-1:HW-2]} : {x[HW-2:0], x[HW-1]};
    endfunction

    function automatic logic [HW-1:0] rotr(input logic [HW-1:0] x, input logic by2);
        return by2 ? {x[1:0], x[HW-1:2]} : {x[0], x[HW-1:1]};
    endfunction

    assign rnd_nx = rnd_q + 4'd1;
    // Shift table is symmetric, so decrypt undoes the same amount at the same index.
    assign two    = (SHIFT_TBL[rnd_nx] == 2);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        rnd_d   = rnd_q;
        e_d     = e_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    e_d     = e;
                    rnd_d   = 4'd0;
                    c_d     = e ? rotl(kp[KPW-1:HW], 1'b0) : kp[KPW-1:HW];
                    d_d     = e ? rotl(kp[HW-1:0], 1'b0)   : kp[HW-1:0];
                end
            end
            RUN: begin
                if (rk_ready) begin
                    if (rnd_q == 4'd15) begin
                        state_d = DONE;
                    end else begin
                        rnd_d = rnd_nx;
                        c_d   = e_q ? rotl(c_q, two) : rotr(c_q, two);
                        d_d   = e_q ? rotl(d_q, two) : rotr(d_q, two);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            rnd_q   <= '0;
            e_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            rnd_q   <= rnd_d;
            e_q     <= e_d;
        end
    end

    des_pc2 u_pc2 (
        .cd ({c_q, d_q}),
        .rk (rk)
    );

    assign rk_valid = (state_q == RUN);
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign rnd      = rnd_q;
endmodule

// File: tb/tb_des_key_sched.sv
// Scoreboard bench for des_key_sched: stimulus queues expected subkeys,
// a negedge monitor checks every presented rk/rnd and the done pulse.
module tb_des_key_sched;
    logic        clk = 1'b0;
    logic        rst, start, e, rk_ready;
    logic [55:0] kp;
    logic [47:0] rk;
    logic        rk_valid, busy, done;
    logic [3:0]  rnd;

    always #5 clk = ~clk;

    des_key_sched dut (
        .clk(clk), .rst(rst), .start(start), .e(e), .kp(kp),
        .rk(rk), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rnd(rnd), .busy(busy), .done(done)
    );

    localparam logic [55:0] KP_REF = 56'hF0CCAAF556678F;
    localparam logic [47:0] ENC [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    typedef struct packed {
        logic [47:0] rk;
        logic [3:0]  rnd;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0, done_cnt = 0, exp_done = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_sched(input logic [55:0] kv, input logic ev);
        exp_t x;
        for (int k = 0; k < 16; k++) begin
            if (kv == KP_REF)   x.rk = ev ? ENC[k] : ENC[15-k];
            else if (kv == '0)  x.rk = '0;
            else                x.rk = '1;
            x.rnd = 4'(k);
            q.push_back(x);
        end
    endtask

    // Monitor: peek while valid (proves stability under stall), pop on handshake.
    initial begin
        logic pend;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                continue;
            end
            chk("done", 64'(done), 64'(pend));
            if (done) done_cnt++;
            pend = 1'b0;
            if (rk_valid) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rk: got %h want none", rk);
                end else begin
                    chk("rk", 64'(rk), 64'(q[0].rk));
                    chk("rnd", 64'(rnd), 64'(q[0].rnd));
                    if (rk_ready) begin
                        pend = (rnd == 4'd15);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    // mode: 0 ready high, 1 random ready + 10-cycle stall at rnd 8,
    //       2 interfering start while running, 3 async reset at rnd 5
    task automatic run(input logic [55:0] kv, input logic ev, input int mode);
        int stall_left;
        stall_left = -1;
        push_sched(kv, ev);
        @(posedge clk); #1;
        kp = kv; e = ev; start = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("latency_valid", 64'(rk_valid), 64'd1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (done) begin
                exp_done++;
                return;
            end
            if (mode == 3 && rk_valid && rnd == 4'd5) begin
                #2;
                rst = 1'b1;
                #1;
                chk("rst_valid", 64'(rk_valid), 64'd0);
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                chk("rst_rk", 64'(rk), 64'd0);
                q.delete();
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
            if (mode == 1) begin
                if (rnd == 4'd8 && stall_left == -1) stall_left = 10;
                if (stall_left > 0) begin
                    rk_ready = 1'b0;
                    stall_left--;
                end else begin
                    rk_ready = 1'($urandom_range(0, 1));
                end
            end
            if (mode == 2) begin
                start = (cyc == 3);
                kp    = ~kv;
                e     = ~ev;
            end
            @(posedge clk); #1;
        end
        total++;
        bad++;
        $display("FAIL timeout: got no done want done within 300 cycles");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; e = 1'b0; kp = '0; rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 64'(rk_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_rk", 64'(rk), 64'd0);
        chk("reset_rnd", 64'(rnd), 64'd0);
        rst = 1'b0;

        run(KP_REF, 1'b1, 0);
        run(KP_REF, 1'b0, 0);
        run(KP_REF, 1'b1, 1);
        run(KP_REF, 1'b0, 1);
        run(KP_REF, 1'b1, 2);
        run(KP_REF, 1'b0, 2);
        run(KP_REF, 1'b1, 3);
        run(KP_REF, 1'b1, 0);
        run(56'h0, 1'b1, 0);
        run('1, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);
        chk("done_count", 64'(done_cnt), 64'(exp_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
